// File: rtl/pkmc_refresh_timer.sv
// rtl/pkmc_refresh_timer.sv - power-up delay and auto-refresh request timer for the SDRAM command FSM
// One shared down-counter times the power-up delay, then the refresh interval; missed ticks queue in pend.
module pkmc_refresh_timer #(
  parameter int INIT_CYCLES    = 5000,
  parameter int REFRESH_CYCLES = 390,
  parameter int CNT_W          = 16,
  parameter int PEND_W         = 3,
  parameter int PEND_MAX       = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ref_en_i,
  input  logic              refresh_ack_i,
  output logic              init_count_o,
  output logic              refresh_req_o,
  output logic              refresh_urgent_o,
  output logic [PEND_W-1:0] pend_count_o,
  output logic              overflow_o
);

  localparam logic [CNT_W-1:0]  INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REF_LOAD  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_SAT  = PEND_W'(PEND_MAX);
  localparam logic [PEND_W-1:0] URG_THR   = PEND_W'(PEND_MAX / 2);

  typedef enum logic {
    PWRUP = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              init_q, init_d;
  logic              req_q, req_d;
  logic              urg_q, urg_d;
  logic              ovf_q, ovf_d;
  logic              tick;
  logic              ackv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PWRUP;
      cnt_q   <= INIT_LOAD;
      pend_q  <= '0;
      init_q  <= 1'b0;
      req_q   <= 1'b0;
      urg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      init_q  <= init_d;
      req_q   <= req_d;
      urg_q   <= urg_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    init_d  = init_q;
    ovf_d   = ovf_q;
    tick    = 1'b0;
    ackv    = 1'b0;

    case (state_q)
      PWRUP: begin
        if (cnt_q == '0) begin
          init_d  = 1'b1;
          cnt_d   = REF_LOAD;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        // Acks at pend == 0 are spurious and must not underflow the queue.
        ackv = refresh_ack_i && (pend_q != '0);
        if (!ref_en_i) begin
          cnt_d = REF_LOAD;
        end else if (cnt_q == '0) begin
          tick  = 1'b1;
          cnt_d = REF_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end

        if (tick && !ackv) begin
          if (pend_q == PEND_SAT) begin
            ovf_d = 1'b1;
          end else begin
            pend_d = pend_q + PEND_W'(1);
          end
        end else if (ackv && !tick) begin
          pend_d = pend_q - PEND_W'(1);
        end
      end
      default: state_d = PWRUP;
    endcase

    // Status flags are derived from the next pend so they register alongside it.
    req_d = (pend_d != '0);
    urg_d = (pend_d >= URG_THR);
  end

  assign init_count_o     = init_q;
  assign refresh_req_o    = req_q;
  assign refresh_urgent_o = urg_q;
  assign pend_count_o     = pend_q;
  assign overflow_o       = ovf_q;

endmodule

// File: doc/pkmc_refresh_timer.md
Name: pkmc_refresh_timer

Overview:
Timing source directly upstream of the SDRAM command FSM and its command logic. Generates the power-up delay flag `init_count_o`, which gates the first PRECHARGE of the init sequence. Generates periodic auto-refresh requests to the FSM and consumes the FSM's one-cycle refresh acknowledge. Missed refresh intervals are queued in a saturating pending counter, so a long burst never silently drops a refresh.

Parameters:
INIT_CYCLES, 5000, clock cycles of power-up delay before init_count_o asserts (100 us at 50 MHz); legal range 2..2^CNT_W
REFRESH_CYCLES, 390, clock cycles between refresh ticks (7.8 us at 50 MHz); legal range 2..2^CNT_W
CNT_W, 16, width of the shared down-counter
PEND_W, 3, width of the pending-refresh counter
PEND_MAX, 7, saturation value of the pending counter; must be <= 2^PEND_W-1 and >= 2

Ports:
clk_i  in  1  system clock; all state changes on the rising edge
rst_i  in  1  asynchronous, active-high reset
ref_en_i  in  1  FSM has finished init (LMR issued); refresh timing runs only while high
refresh_ack_i  in  1  one-cycle pulse from the FSM when it issues AUTO_REFR for a queued refresh
init_count_o  out  1  power-up delay elapsed; sticky until reset
refresh_req_o  out  1  one or more refreshes pending (pend != 0)
refresh_urgent_o  out  1  pend >= PEND_MAX/2 (integer division); the FSM must refresh before its next access
pend_count_o  out  PEND_W  current pending-refresh count
overflow_o  out  1  sticky error flag: a tick was lost at saturation

Behaviour:
- Reset (asynchronous, active-high), values while rst_i is high:
  - all outputs 0
  - state = PWRUP
  - counter = INIT_CYCLES-1
  - pend = 0
- State machine, two states:
  - PWRUP:
    - counter decrements once per edge.
    - On the edge where counter == 0: set init_count_o=1, load counter = REFRESH_CYCLES-1, go to RUN.
    - Result: init_count_o is first high after exactly INIT_CYCLES rising edges following rst_i deassertion.
    - ref_en_i and refresh_ack_i are ignored; pend stays 0.
  - RUN:
    - init_count_o stays 1.
    - ref_en_i = 0: counter is held at REFRESH_CYCLES-1 (reload every edge). pend is retained and acks are still honoured.
    - ref_en_i = 1: counter decrements. When counter == 0, tick = 1 for that cycle and counter reloads REFRESH_CYCLES-1.
    - Result: refresh_req_o rises immediately after the REFRESH_CYCLES-th consecutive edge with ref_en_i=1.
- Pending counter update (registered, same edge as the tick). Let ackv = refresh_ack_i AND pend != 0; acks at pend == 0 are ignored.
  - tick and not ackv: pend+1, unless pend == PEND_MAX. At PEND_MAX pend stays PEND_MAX and overflow_o is set to 1 (sticky).
  - ackv and not tick: pend-1.
  - tick and ackv together: pend unchanged, including at PEND_MAX; overflow_o is not set.
  - neither: unchanged.
- Outputs:
  - refresh_req_o, refresh_urgent_o and pend_count_o are registered, updated on the same edge as pend, and consistent with pend in the following cycle.
  - No combinational path from any input to any output.
- Handshake:
  - The FSM may pulse refresh_ack_i at most once per AUTO_REFR issued. Each valid pulse retires exactly one refresh.
  - Holding ack high for N cycles retires min(N, pend) refreshes; stated behaviour, not an error.
- Reset mid-operation: immediate return to PWRUP.
  - init_count_o drops asynchronously; pend and overflow_o are cleared.
  - The full INIT_CYCLES delay is re-run after release.
- Counter width: INIT_CYCLES-1 and REFRESH_CYCLES-1 must fit in CNT_W. No wrap-around is possible in legal configurations.

Test Plan (bench parameters INIT_CYCLES=10, REFRESH_CYCLES=8, PEND_MAX=4, PEND_W=3):
1. Release rst_i, hold ref_en_i=0 -> init_count_o=0 through edge 9 and 1 from edge 10 onward; refresh_req_o stays 0 for 100 cycles.
2. After init, raise ref_en_i, never ack -> pend_count_o reads 1,2,3,4 after edges 8,16,24,32 after ref_en_i rise.
   - refresh_urgent_o goes 1 when pend reaches 2.
   - At edge 40 pend stays 4 and overflow_o goes 1 and stays 1.
3. pend=1, then pulse refresh_ack_i for one cycle -> pend_count_o=0 and refresh_req_o=0 next cycle. A second ack at pend=0 leaves pend 0.
4. Align an ack pulse with the tick edge at pend=4 -> pend stays 4 and overflow_o stays 0. Repeat with pend=0 -> pend becomes 1.
5. Toggle ref_en_i low for 3 cycles at counter=2, then high -> next tick occurs 8 edges after re-enable; pend is unchanged during the low window.
6. Assert rst_i asynchronously (between edges) with pend=3 and overflow_o=1 -> all outputs 0 before the next edge. After release, init_count_o returns only after 10 edges.
